crc_stream: RTL and testbench
=============================

// Module: crc_stream
// PURPOSE
//  Parametrised CRC generator/checker for framed data, DW bits per clock, MSB first.
//  Generalises the serial CRC5 engine to any width, polynomial, init and xor-out value.
//  Adds frame handshaking, a check mode, and optional CRC append in generate mode.
//  Sits between a packet source and a serialiser/link layer.
// PARAMETERS
//  CW       5      CRC width in bits (2..32)
//  POLY     5'h05  generator polynomial, implicit x^CW term omitted (default x^5+x^2+1)
//  INIT     5'h1F  register value loaded on a sof beat
//  XOR_OUT  5'h00  XORed onto the register to form crc_out
//  DW       1      data bits per beat (1..32); in_data[DW-1] is processed first
//  RESIDUE  5'h00  raw register value that means a good frame in check mode
//  APPEND   1      1: generate mode appends the CRC on out_*; 0: never appends
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous reset, active low
//  mode       in   1   0 = generate, 1 = check; sampled on sof beat
//  in_valid   in   1   input beat valid
//  in_ready   out  1   input beat accepted when in_valid & in_ready
//  in_sof     in   1   first beat of frame
//  in_last    in   1   last beat of frame (may coincide with in_sof)
//  in_data    in   DW  payload bits, MSB first
//  out_valid  out  1   appended CRC word valid
//  out_ready  in   1   downstream accepts out_data
//  out_data   out  DW  CRC word: crc_out MSB first, last word zero-padded in LSBs
//  crc_out    out  CW  final CRC (register ^ XOR_OUT), held until next frame end
//  crc_valid  out  1   1-cycle pulse: crc_out/crc_ok updated
//  crc_ok     out  1   check mode: raw register == RESIDUE; 0 in generate mode
//  frame_err  out  1   1-cycle pulse: protocol violation (see below)
// BEHAVIOUR
//  Reset: state=IDLE, register=INIT, in_ready=1, out_valid=0, out_data=0,
//   crc_out=0, crc_valid=0, crc_ok=0, frame_err=0. Reset mid-frame abandons the frame.
//  Per accepted beat: DW sequential steps of
//   fb=r[CW-1]^d; r={r[CW-2:0],1'b0}^(fb?POLY:0).
//   A sof beat starts from INIT, not from r.
//  FSM states: IDLE, RUN, APPEND.
//  IDLE: sof beat -> RUN, latch mode; sof&last beat -> frame ends at once.
//   Beat without sof -> ignored, frame_err pulse next cycle.
//  RUN: data beats update r. A sof beat aborts the frame: frame_err pulses,
//   r restarts from INIT, stay in RUN.
//  Frame end (last beat accepted): next cycle crc_valid=1, crc_out=r^XOR_OUT,
//   crc_ok=(mode_q && r==RESIDUE).
//   APPEND=1 & generate mode -> APPEND; otherwise -> IDLE.
//  APPEND: in_ready=0. out_valid=1 from the crc_valid cycle.
//   NW=ceil(CW/DW) words, held stable while out_ready=0.
//   Word counter advances on out_valid&out_ready; last word accepted -> IDLE,
//   in_ready=1 next cycle.
//  in_ready=1 in IDLE/RUN, 0 in APPEND. Throughput is one beat per clock.
//  No combinational path from any input to any output.
// STRUCTURE
//  crc_defs.vh: state encodings, MODE_GEN/MODE_CHK constants.
//  Sub-module crc_step: combinational next-register for one DW beat (CW, POLY, DW
//   params). Instantiated once; FSM, counter and output registers stay in crc_stream.
// TESTING  (INIT=0, XOR_OUT=0 unless noted; DW=1 with 8 one-bit beats per byte)
//  Gen byte 8'h01 -> crc_valid 1 cycle after last beat, crc_out=5'h05.
//   APPEND: out_data 0,0,1,0,1 over 5 beats.
//  Gen byte 8'h80 -> crc_out=5'h0E. out_ready low 3 cycles mid-append -> word held,
//   in_ready stays 0.
//  Check 8'h80 then bits 0,1,1,1,0 -> crc_ok=1. Flip one payload bit -> crc_ok=0.
//  DW=8, CW=5: one sof&last beat 8'h80 -> crc_out=5'h0E,
//   single out_data=8'b01110000.
//  sof in RUN after 3 bits of 8'h01 -> frame_err pulse.
//   Restarted 8'h01 still gives 5'h05. Beat without sof in IDLE -> frame_err, r unchanged.
//  rst_n low mid-APPEND for one cycle -> all outputs at reset values immediately,
//   next frame 8'h01 -> 5'h05.

Source files
------------

// File: rtl/crc_stream_pkg.sv
// ----------------------------------------------------------------------------
// crc_stream_pkg
//   Shared definitions for the crc_stream block.
//   - state_t   : frame FSM states (idle, payload running, CRC append)
//   - MODE_GEN  : generate mode (mode input = 0)
//   - MODE_CHK  : check mode    (mode input = 1)
//   - num_words : number of DW-bit words needed to carry a CW-bit CRC
// ----------------------------------------------------------------------------
package crc_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_APPEND = 2'd2
   } state_t;

   localparam logic MODE_GEN = 1'b0;
   localparam logic MODE_CHK = 1'b1;

   function automatic int num_words(input int cw, input int dw);
      return (cw + dw - 1) / dw;
   endfunction

endpackage

// File: rtl/crc_stream_step.sv
// ----------------------------------------------------------------------------
// crc_stream_step
//   Combinational CRC register update for one DW-bit beat, MSB first.
//   Each data bit performs: fb = r[CW-1] ^ d; r = {r[CW-2:0],0} ^ (fb ? POLY : 0)
// Ports
//   crc_in   in  CW  register value before the beat
//   data_in  in  DW  beat payload, data_in[DW-1] processed first
//   crc_next out CW  register value after all DW bits
// ----------------------------------------------------------------------------
module crc_stream_step #(
   parameter int            CW   = 5,
   parameter logic [CW-1:0] POLY = CW'(5'h05),
   parameter int            DW   = 1
) (
   input  logic [CW-1:0] crc_in,
   input  logic [DW-1:0] data_in,
   output logic [CW-1:0] crc_next
);

   logic [CW-1:0] r;
   logic          fb;

   always_comb begin
      r  = crc_in;
      fb = 1'b0;
      for (int i = DW - 1; i >= 0; i--) begin
         fb = r[CW-1] ^ data_in[i];
         r  = {r[CW-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
      crc_next = r;
   end

endmodule

// File: rtl/crc_stream.sv
// ----------------------------------------------------------------------------
// crc_stream
//   Framed CRC generator / checker, DW bits per beat, MSB first.
//   Generate mode can append the finished CRC on the out_* stream; check mode
//   compares the raw register against RESIDUE at frame end.
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   mode                  0 generate / 1 check, sampled on the sof beat
//   in_valid/in_ready     input beat handshake
//   in_sof/in_last        frame delimiters (may coincide)
//   in_data [DW]          payload, MSB first
//   out_valid/out_ready   appended CRC word handshake
//   out_data [DW]         CRC word, MSB first, last word zero-padded in LSBs
//   crc_out [CW]          register ^ XOR_OUT, held until next frame end
//   crc_valid             1-cycle pulse when crc_out/crc_ok update
//   crc_ok                check mode: raw register == RESIDUE
//   frame_err             1-cycle pulse on protocol violation
// All outputs are registered.
// ----------------------------------------------------------------------------
module crc_stream
   import crc_stream_pkg::*;
#(
   parameter int            CW      = 5,
   parameter logic [CW-1:0] POLY    = CW'(5'h05),
   parameter logic [CW-1:0] INIT    = CW'(5'h1F),
   parameter logic [CW-1:0] XOR_OUT = CW'(5'h00),
   parameter int            DW      = 1,
   parameter logic [CW-1:0] RESIDUE = CW'(5'h00),
   parameter bit            APPEND  = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          mode,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_sof,
   input  logic          in_last,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [CW-1:0] crc_out,
   output logic          crc_valid,
   output logic          crc_ok,
   output logic          frame_err
);

   localparam int NW    = num_words(CW, DW);
   localparam int PW    = NW * DW;
   localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;

   state_t         state_q, state_d;
   logic [CW-1:0]  r_q, r_d;
   logic           mode_q, mode_d;
   logic           in_ready_q, in_ready_d;
   logic           out_valid_q, out_valid_d;
   logic [DW-1:0]  out_data_q, out_data_d;
   logic [PW-1:0]  pad_q, pad_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic [CW-1:0]  crc_out_q, crc_out_d;
   logic           crc_valid_q, crc_valid_d;
   logic           crc_ok_q, crc_ok_d;
   logic           frame_err_q, frame_err_d;

   logic           beat_acc;
   logic           mode_eff;
   logic [CW-1:0]  step_in;
   logic [CW-1:0]  step_out;
   logic [PW-1:0]  pad_load;
   logic [PW-1:0]  pad_shift;

   // A sof beat always starts from INIT, regardless of the running register.
   assign step_in  = in_sof ? INIT : r_q;
   // The mode of a frame ending on its own sof beat is the live input.
   assign mode_eff = in_sof ? mode : mode_q;
   assign beat_acc = in_valid & in_ready_q;

   crc_stream_step #(
      .CW   (CW),
      .POLY (POLY),
      .DW   (DW)
   ) u_step (
      .crc_in   (step_in),
      .data_in  (in_data),
      .crc_next (step_out)
   );

   // Final CRC left-justified in the word buffer so the padding lands in the
   // LSBs of the last word.
   assign pad_load  = PW'(step_out ^ XOR_OUT) << (PW - CW);
   assign pad_shift = pad_q << DW;

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      mode_d      = mode_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      pad_d       = pad_q;
      wcnt_d      = wcnt_q;
      crc_out_d   = crc_out_q;
      crc_ok_d    = crc_ok_q;
      crc_valid_d = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (beat_acc) begin
               if (!in_sof && (state_q == ST_IDLE)) begin
                  // Stray beat outside a frame: dropped, register untouched.
                  frame_err_d = 1'b1;
               end else begin
                  // sof inside a frame aborts it and restarts from INIT.
                  if (in_sof && (state_q == ST_RUN)) frame_err_d = 1'b1;
                  if (in_sof) mode_d = mode;
                  r_d = step_out;
                  if (in_last) begin
                     crc_valid_d = 1'b1;
                     crc_out_d   = step_out ^ XOR_OUT;
                     crc_ok_d    = (mode_eff == MODE_CHK) && (step_out == RESIDUE);
                     if (APPEND && (mode_eff == MODE_GEN)) begin
                        state_d     = ST_APPEND;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        pad_d       = pad_load;
                        out_data_d  = pad_load[PW-1 -: DW];
                        wcnt_d      = '0;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end else begin
                     state_d = ST_RUN;
                  end
               end
            end
         end
         ST_APPEND: begin
            if (out_valid_q && out_ready) begin
               if (wcnt_q == CNT_W'(NW - 1)) begin
                  state_d     = ST_IDLE;
                  in_ready_d  = 1'b1;
                  out_valid_d = 1'b0;
                  out_data_d  = '0;
               end else begin
                  wcnt_d     = wcnt_q + CNT_W'(1);
                  pad_d      = pad_shift;
                  out_data_d = pad_shift[PW-1 -: DW];
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_data_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         r_q         <= INIT;
         mode_q      <= MODE_GEN;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         pad_q       <= '0;
         wcnt_q      <= '0;
         crc_out_q   <= '0;
         crc_valid_q <= 1'b0;
         crc_ok_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         mode_q      <= mode_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         pad_q       <= pad_d;
         wcnt_q      <= wcnt_d;
         crc_out_q   <= crc_out_d;
         crc_valid_q <= crc_valid_d;
         crc_ok_q    <= crc_ok_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign crc_out   = crc_out_q;
   assign crc_valid = crc_valid_q;
   assign crc_ok    = crc_ok_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_crc_stream.sv
// ----------------------------------------------------------------------------
// tb_crc_stream
//   Directed bench for crc_stream: a DW=1 instance driven bit by bit and a
//   DW=8 instance for the single-beat frame. Expected CRC results and
//   appended words are queued when frames are driven and popped by a monitor
//   as the DUT produces them.
// ----------------------------------------------------------------------------
module tb_crc_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       mode, in_valid, in_sof, in_last, out_ready;
   logic [0:0] in_data;
   logic       in_ready, out_valid, crc_valid, crc_ok, frame_err;
   logic [0:0] out_data;
   logic [4:0] crc_out;

   logic       mode_8, in_valid_8, in_sof_8, in_last_8, out_ready_8;
   logic [7:0] in_data_8;
   logic       in_ready_8, out_valid_8, crc_valid_8, crc_ok_8, frame_err_8;
   logic [7:0] out_data_8;
   logic [4:0] crc_out_8;

   crc_stream #(
      .CW(5), .POLY(5'h05), .INIT(5'h00), .XOR_OUT(5'h00),
      .DW(1), .RESIDUE(5'h00), .APPEND(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
      .in_ready(in_ready), .in_sof(in_sof), .in_last(in_last),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .crc_out(crc_out), .crc_valid(crc_valid),
      .crc_ok(crc_ok), .frame_err(frame_err)
   );

   crc_stream #(
      .CW(5), .POLY(5'h05), .INIT(5'h00), .XOR_OUT(5'h00),
      .DW(8), .RESIDUE(5'h00), .APPEND(1'b1)
   ) dut8 (
      .clk(clk), .rst_n(rst_n), .mode(mode_8), .in_valid(in_valid_8),
      .in_ready(in_ready_8), .in_sof(in_sof_8), .in_last(in_last_8),
      .in_data(in_data_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
      .out_data(out_data_8), .crc_out(crc_out_8), .crc_valid(crc_valid_8),
      .crc_ok(crc_ok_8), .frame_err(frame_err_8)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [4:0] crc;
      logic       ok;
   } exp_t;

   exp_t exp_q[$];
   logic wq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bit-serial reference CRC (CW=5, POLY=0x05, INIT=0), MSB first.
   function automatic logic [4:0] mdl(input logic [31:0] v, input int n);
      logic [4:0] r;
      logic       fb;
      r = 5'h00;
      for (int i = n - 1; i >= 0; i--) begin
         fb = r[4] ^ v[i];
         r  = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
      end
      return r;
   endfunction

   task automatic beat(input logic sof, input logic last, input logic d, input logic m);
      mode     = m;
      in_valid = 1'b1;
      in_sof   = sof;
      in_last  = last;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_last  = 1'b0;
      in_data  = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] v, input int n, input logic m);
      exp_t       e;
      logic [4:0] r;
      r     = mdl(v, n);
      e.crc = r;
      e.ok  = m && (r == 5'h00);
      exp_q.push_back(e);
      if (!m) for (int b = 4; b >= 0; b--) wq.push_back(r[b]);
   endtask

   task automatic send_frame(input logic [31:0] v, input int n, input logic m);
      push_exp(v, n, m);
      for (int i = n - 1; i >= 0; i--) beat(i == n - 1, i == 0, v[i], m);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(tag, 32'(in_ready), 32'h1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),  32'h1);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      chk({tag, "_out_data"},  32'(out_data),  32'h0);
      chk({tag, "_crc_out"},   32'(crc_out),   32'h0);
      chk({tag, "_crc_valid"}, 32'(crc_valid), 32'h0);
      chk({tag, "_crc_ok"},    32'(crc_ok),    32'h0);
      chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
   endtask

   // Scoreboard monitor for the DW=1 instance.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (crc_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_crc_valid", 32'(crc_valid), 32'h0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sb_crc_out", 32'(crc_out), 32'(e.crc));
               chk("sb_crc_ok",  32'(crc_ok),  32'(e.ok));
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (wq.size() == 0) begin
               chk("sb_unexpected_out_valid", 32'(out_valid), 32'h0);
            end else begin
               logic w;
               w = wq.pop_front();
               chk("sb_out_data", 32'(out_data), 32'(w));
            end
         end
      end
   end

   initial begin
      logic [31:0] v;
      logic [0:0]  held;

      rst_n = 1'b0;
      mode = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_last = 1'b0;
      in_data = 1'b0; out_ready = 1'b1;
      mode_8 = 1'b0; in_valid_8 = 1'b0; in_sof_8 = 1'b0; in_last_8 = 1'b0;
      in_data_8 = 8'h00; out_ready_8 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      chk("reset_in_ready_8", 32'(in_ready_8), 32'h1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Generate 8'h01 -> 5'h05, appended 0,0,1,0,1
      send_frame(32'h01, 8, 1'b0);
      chk("gen01_crc_valid", 32'(crc_valid), 32'h1);
      chk("gen01_crc_out",   32'(crc_out),   32'h05);
      chk("gen01_out_valid", 32'(out_valid), 32'h1);
      chk("gen01_in_ready",  32'(in_ready),  32'h0);
      @(posedge clk);
      #1;
      chk("gen01_crc_valid_pulse", 32'(crc_valid), 32'h0);
      wait_idle("gen01_idle");
      chk("gen01_words_drained", 32'(wq.size()), 32'h0);

      // Generate 8'h80 -> 5'h0E with a 3-cycle stall mid-append
      send_frame(32'h80, 8, 1'b0);
      chk("gen80_crc_out", 32'(crc_out), 32'h0E);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
      held = out_data;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("stall_out_data",  32'(out_data),  32'(held));
         chk("stall_out_valid", 32'(out_valid), 32'h1);
         chk("stall_in_ready",  32'(in_ready),  32'h0);
      end
      out_ready = 1'b1;
      wait_idle("gen80_idle");

      // Check mode: 8'h80 followed by its CRC bits 0,1,1,1,0
      v = 32'h100E;
      send_frame(v, 13, 1'b1);
      chk("chk_good_crc_ok",    32'(crc_ok),    32'h1);
      chk("chk_good_out_valid", 32'(out_valid), 32'h0);
      chk("chk_good_in_ready",  32'(in_ready),  32'h1);
      v = v ^ 32'h0100;
      send_frame(v, 13, 1'b1);
      chk("chk_bad_crc_ok", 32'(crc_ok), 32'h0);

      // sof inside a running frame: abort and restart with 8'h01
      beat(1'b1, 1'b0, 1'b0, 1'b0);
      beat(1'b0, 1'b0, 1'b0, 1'b0);
      beat(1'b0, 1'b0, 1'b0, 1'b0);
      chk("pre_abort_frame_err", 32'(frame_err), 32'h0);
      push_exp(32'h01, 8, 1'b0);
      v = 32'h01;
      for (int i = 7; i >= 0; i--) begin
         beat(i == 7, i == 0, v[i], 1'b0);
         if (i == 7) chk("abort_frame_err", 32'(frame_err), 32'h1);
         if (i == 6) chk("abort_frame_err_pulse", 32'(frame_err), 32'h0);
      end
      chk("restart_crc_out", 32'(crc_out), 32'h05);
      wait_idle("restart_idle");

      // Beat without sof while idle: dropped with frame_err
      beat(1'b0, 1'b1, 1'b1, 1'b0);
      chk("stray_frame_err", 32'(frame_err), 32'h1);
      chk("stray_crc_valid", 32'(crc_valid), 32'h0);
      chk("stray_in_ready",  32'(in_ready),  32'h1);
      @(posedge clk);
      #1;
      chk("stray_frame_err_pulse", 32'(frame_err), 32'h0);
      send_frame(32'h01, 8, 1'b0);
      chk("after_stray_crc_out", 32'(crc_out), 32'h05);
      wait_idle("after_stray_idle");

      // A few random generate frames against the reference model
      for (int k = 0; k < 3; k++) begin
         v = 32'($urandom_range(0, 255));
         send_frame(v, 8, 1'b0);
         wait_idle("rand_idle");
      end

      // DW=8 single sof&last beat 8'h80
      in_valid_8 = 1'b1; in_sof_8 = 1'b1; in_last_8 = 1'b1;
      in_data_8 = 8'h80; mode_8 = 1'b0;
      @(posedge clk);
      #1;
      in_valid_8 = 1'b0; in_sof_8 = 1'b0; in_last_8 = 1'b0; in_data_8 = 8'h00;
      chk("dw8_crc_valid", 32'(crc_valid_8), 32'h1);
      chk("dw8_crc_out",   32'(crc_out_8),   32'h0E);
      chk("dw8_crc_ok",    32'(crc_ok_8),    32'h0);
      chk("dw8_out_valid", 32'(out_valid_8), 32'h1);
      chk("dw8_out_data",  32'(out_data_8),  32'h70);
      chk("dw8_in_ready",  32'(in_ready_8),  32'h0);
      @(posedge clk);
      #1;
      chk("dw8_out_valid_done", 32'(out_valid_8), 32'h0);
      chk("dw8_in_ready_done",  32'(in_ready_8),  32'h1);
      chk("dw8_frame_err",      32'(frame_err_8), 32'h0);

      // Reset asserted mid-append for one cycle
      send_frame(32'h01, 8, 1'b0);
      @(posedge clk);
      #1;
      chk("pre_reset_out_valid", 32'(out_valid), 32'h1);
      rst_n = 1'b0;
      #1;
      chk_reset("midreset");
      wq.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_frame(32'h01, 8, 1'b0);
      chk("post_reset_crc_out", 32'(crc_out), 32'h05);
      wait_idle("post_reset_idle");

      @(posedge clk);
      #1;
      chk("final_exp_drained",   32'(exp_q.size()), 32'h0);
      chk("final_words_drained", 32'(wq.size()),    32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
